// File: rtl/multi_channel_timer_if.sv
// multi_channel_timer_if: command bus and irq/ack handshake of the multi-channel timer
interface multi_channel_timer_if #(
  parameter int N_CH = 4,
  parameter int WIDTH = 32,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
);
  logic [1:0] cmd;
  logic [CH_W-1:0] cmd_sel;
  logic [WIDTH-1:0] cmd_interval;
  logic cmd_periodic;
  logic irq_ack;
  logic irq;
  logic [CH_W-1:0] irq_ch;
  modport master (output cmd, cmd_sel, cmd_interval, cmd_periodic, irq_ack, input irq, irq_ch);
  modport slave (input cmd, cmd_sel, cmd_interval, cmd_periodic, irq_ack, output irq, irq_ch);
endinterface

// File: rtl/multi_channel_timer.sv
// multi_channel_timer: N_CH down-counting timers with pending/overrun latching and fixed-priority irq delivery
module multi_channel_timer #(
  parameter int N_CH = 4,
  parameter int WIDTH = 32,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic halt,
  input  logic block,
  multi_channel_timer_if.slave bus,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overrun,
  input  logic [CH_W-1:0] rd_sel,
  output logic [WIDTH-1:0] rd_count
);
  typedef enum logic {IDLE, ASSERT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] interval [N_CH];
  logic [WIDTH-1:0] counter [N_CH];
  logic [N_CH-1:0] armed, periodic;
  logic [CH_W-1:0] irq_ch_n, low;
  logic ack_clr, stop_cmd;
  assign stop_cmd = bus.cmd == 2'b10 || (bus.cmd == 2'b01 && bus.cmd_interval == '0);
  assign bus.irq = state == ASSERT;
  assign rd_count = int'(rd_sel) < N_CH ? counter[rd_sel] : '0;
  always_comb begin
    low = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (pending[i]) low = CH_W'(i);
  end
  always_comb begin
    state_n = state;
    irq_ch_n = bus.irq_ch;
    ack_clr = 1'b0;
    if (state == IDLE) begin
      if (!block && |pending) begin
        state_n = ASSERT;
        irq_ch_n = low;
      end
    end else if (bus.irq_ack) begin
      ack_clr = 1'b1;
      state_n = IDLE;
    end else if (stop_cmd && bus.cmd_sel == bus.irq_ch) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      bus.irq_ch <= '0;
    end else begin
      state <= state_n;
      bus.irq_ch <= irq_ch_n;
    end
  end
  // a command on a channel overrides its expiry; a same-cycle expiry overrides an ack
  always_ff @(posedge clock) begin
    if (reset) begin
      armed <= '0;
      periodic <= '0;
      pending <= '0;
      overrun <= '0;
      for (int i = 0; i < N_CH; i++) begin
        interval[i] <= '0;
        counter[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ack_clr && bus.irq_ch == CH_W'(i)) pending[i] <= 1'b0;
        if (bus.cmd != 2'b00 && bus.cmd_sel == CH_W'(i)) begin
          if (stop_cmd) begin
            armed[i] <= 1'b0;
            counter[i] <= '0;
            pending[i] <= 1'b0;
            overrun[i] <= 1'b0;
          end else if (bus.cmd == 2'b01) begin
            interval[i] <= bus.cmd_interval;
            counter[i] <= bus.cmd_interval;
            periodic[i] <= bus.cmd_periodic;
            armed[i] <= 1'b1;
          end else begin
            counter[i] <= interval[i];
            armed[i] <= interval[i] != '0;
          end
        end else if (armed[i] && !halt) begin
          if (counter[i] == WIDTH'(1)) begin
            pending[i] <= 1'b1;
            if (pending[i] && !(ack_clr && bus.irq_ch == CH_W'(i))) overrun[i] <= 1'b1;
            counter[i] <= periodic[i] ? interval[i] : '0;
            armed[i] <= periodic[i];
          end else begin
            counter[i] <= counter[i] - WIDTH'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_channel_timer.sv
// tb_multi_channel_timer: directed and random stimulus against a deadline-based reference model
module tb_multi_channel_timer;
  localparam int N_CH = 4;
  localparam int WIDTH = 32;
  localparam int CH_W = 2;
  logic clock = 1'b0;
  logic reset, halt, block;
  logic [N_CH-1:0] pending, overrun;
  logic [CH_W-1:0] rd_sel;
  logic [WIDTH-1:0] rd_count;
  int checks = 0;
  int errors = 0;
  multi_channel_timer_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();
  multi_channel_timer #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .halt(halt), .block(block), .bus(bus),
    .pending(pending), .overrun(overrun), .rd_sel(rd_sel), .rd_count(rd_count)
  );
  always #5 clock = ~clock;
  // model: each armed channel expires at an absolute edge number; halted edges push deadlines back
  longint now = 0;
  longint deadline [N_CH];
  longint ival [N_CH];
  bit per [N_CH], arm [N_CH], pnd [N_CH], ovr [N_CH];
  bit m_irq = 0;
  int m_ch = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, now);
    end
  endtask
  function automatic longint model_rd(input int i);
    return arm[i] ? deadline[i] - now : 0;
  endfunction
  task automatic model_edge();
    bit opnd [N_CH];
    bit stop_cmd;
    int ack_ch;
    now++;
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        arm[i] = 0; per[i] = 0; pnd[i] = 0; ovr[i] = 0; ival[i] = 0; deadline[i] = 0;
      end
      m_irq = 0;
      m_ch = 0;
      return;
    end
    stop_cmd = bus.cmd == 2'b10 || (bus.cmd == 2'b01 && bus.cmd_interval == 0);
    ack_ch = -1;
    opnd = pnd;
    if (m_irq) begin
      if (bus.irq_ack) begin
        ack_ch = m_ch;
        m_irq = 0;
      end else if (stop_cmd && int'(bus.cmd_sel) == m_ch) m_irq = 0;
    end else if (!block) begin
      for (int i = 0; i < N_CH; i++)
        if (pnd[i]) begin
          m_irq = 1;
          m_ch = i;
          break;
        end
    end
    if (ack_ch >= 0) pnd[ack_ch] = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.cmd != 2'b00 && int'(bus.cmd_sel) == i) begin
        if (stop_cmd) begin
          arm[i] = 0; pnd[i] = 0; ovr[i] = 0;
        end else if (bus.cmd == 2'b01) begin
          ival[i] = bus.cmd_interval; per[i] = bus.cmd_periodic; arm[i] = 1;
          deadline[i] = now + ival[i];
        end else begin
          arm[i] = ival[i] != 0;
          deadline[i] = now + ival[i];
        end
      end else if (arm[i]) begin
        if (halt) deadline[i]++;
        else if (deadline[i] == now) begin
          pnd[i] = 1;
          if (opnd[i] && ack_ch != i) ovr[i] = 1;
          if (per[i]) deadline[i] = now + ival[i];
          else arm[i] = 0;
        end
      end
    end
  endtask
  task automatic compare();
    logic [N_CH-1:0] ep, eo;
    for (int i = 0; i < N_CH; i++) begin
      ep[i] = pnd[i];
      eo[i] = ovr[i];
    end
    check("irq", bus.irq, m_irq);
    check("irq_ch", bus.irq_ch, m_ch);
    check("pending", pending, ep);
    check("overrun", overrun, eo);
    check("rd_count", rd_count, model_rd(rd_sel));
  endtask
  task automatic cycle(input logic [1:0] c, input int s, input int iv, input bit p,
                       input bit h, input bit b, input bit a, input bit r);
    bus.cmd = c;
    bus.cmd_sel = CH_W'(s);
    bus.cmd_interval = WIDTH'(iv);
    bus.cmd_periodic = p;
    halt = h;
    block = b;
    bus.irq_ack = a;
    reset = r;
    rd_sel = CH_W'($urandom_range(0, N_CH - 1));
    @(posedge clock);
    model_edge();
    #1;
    compare();
  endtask
  task automatic idle(input int n, input bit h, input bit b, input bit a);
    for (int k = 0; k < n; k++) cycle(2'b00, 0, 0, 0, h, b, a, 0);
  endtask
  initial begin
    cycle(2'b00, 0, 0, 0, 0, 0, 0, 1);
    cycle(2'b00, 0, 0, 0, 0, 0, 0, 1);
    cycle(2'b01, 0, 5, 0, 0, 0, 0, 0);
    idle(6, 0, 0, 0);
    idle(22, 0, 0, 1);
    cycle(2'b01, 1, 3, 1, 0, 0, 1, 0);
    idle(4, 0, 0, 1);
    idle(2, 1, 0, 1);
    idle(10, 0, 0, 1);
    cycle(2'b10, 1, 0, 0, 0, 0, 1, 0);
    idle(3, 0, 0, 1);
    cycle(2'b01, 3, 4, 0, 0, 0, 0, 0);
    cycle(2'b01, 2, 4, 0, 0, 0, 0, 0);
    idle(12, 0, 0, 1);
    cycle(2'b01, 0, 1, 0, 0, 1, 0, 0);
    idle(10, 0, 1, 0);
    idle(4, 0, 0, 1);
    cycle(2'b01, 0, 2, 1, 0, 0, 0, 0);
    idle(7, 0, 0, 0);
    cycle(2'b10, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0, 0, 0);
    cycle(2'b01, 0, 0, 1, 0, 0, 0, 0);
    idle(5, 0, 0, 0);
    cycle(2'b11, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0, 0, 0);
    cycle(2'b01, 1, 3, 1, 0, 0, 0, 0);
    cycle(2'b01, 2, 9, 0, 0, 0, 0, 0);
    idle(5, 0, 0, 0);
    cycle(2'b00, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < N_CH; i++) begin
      rd_sel = CH_W'(i);
      #1;
      check("rd_count_after_reset", rd_count, 0);
    end
    for (int k = 0; k < 4000; k++)
      cycle(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            $urandom_range(0, N_CH - 1), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
